legv8_instr_encoder_loader: RTL and testbench

Inverse of the single-cycle opcode decoder. Accepts symbolic LEGv8 instructions (operation class plus register and immediate fields) over a valid/ready handshake. Packs each into a 32-bit machine word per its format (R, D, I, CB, B). Writes the words sequentially into instruction memory through an acknowledged write port, so self-check benches and boot logic can build programs without hand-assembled hex.

---
 rtl/legv8_isa_pkg.sv | 50 +++++
 rtl/legv8_instr_encoder_loader_if.sv | 32 +++
 rtl/legv8_instr_pack.sv | 46 ++++
 rtl/legv8_instr_encoder_loader.sv | 136 +++++++++++++
 tb/tb_legv8_instr_encoder_loader.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_isa_pkg.sv
// LEGv8 ISA constants shared by the encoder/loader and the opcode decoder.
// Holds the op enum, opcode prefixes, field positions and immediate limits.
package legv8_isa_pkg;

  typedef enum logic [3:0] {
    OP_LDUR = 4'd0,
    OP_STUR = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_ORR  = 4'd5,
    OP_ORRI = 4'd6,
    OP_LSL  = 4'd7,
    OP_CBZ  = 4'd8,
    OP_B    = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENC,
    S_WRITE
  } ldr_state_e;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam int OPC_LSB    = 21;
  localparam int RM_LSB     = 16;
  localparam int SHAMT_LSB  = 10;
  localparam int RN_LSB     = 5;
  localparam int RD_LSB     = 0;
  localparam int D_IMM_LSB  = 12;
  localparam int I_IMM_LSB  = 10;
  localparam int CB_IMM_LSB = 5;

  localparam int D_IMM_MIN  = -256;
  localparam int D_IMM_MAX  = 255;
  localparam int I_IMM_MAX  = 4095;
  localparam int CB_IMM_MIN = -(1 << 18);
  localparam int CB_IMM_MAX = (1 << 18) - 1;

endpackage

// File: rtl/legv8_instr_encoder_loader_if.sv
// Field handshake plus instruction-memory write port of the loader.
// master: program source / memory side; slave: the loader.
interface legv8_instr_encoder_loader_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [5:0]        shamt;
  logic [25:0]       imm;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, op, rd, rn, rm,
    output shamt, imm, mem_ack,
    input  in_ready, mem_wr_en,
    input  mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op, rd, rn, rm,
    input  shamt, imm, mem_ack,
    output in_ready, mem_wr_en,
    output mem_addr, mem_wdata
  );
endinterface

// File: rtl/legv8_instr_pack.sv
// Combinational LEGv8 field packer: op/rd/rn/rm/shamt/imm in, word/err out.
// err flags an illegal op or an immediate outside its format's range.
module legv8_instr_pack
  import legv8_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = {{6{imm[25]}}, imm};

  always_comb begin
    word = '0;
    err  = 1'b0;
    unique case (op)
      OP_LDUR, OP_STUR: begin
        word = {(op == OP_LDUR) ? OPC_LDUR : OPC_STUR,
                imm[8:0], 2'b00, rn, rd};
        err  = (simm < D_IMM_MIN) || (simm > D_IMM_MAX);
      end
      OP_ADD: word = {OPC_ADD, rm, 6'd0, rn, rd};
      OP_SUB: word = {OPC_SUB, rm, 6'd0, rn, rd};
      OP_AND: word = {OPC_AND, rm, 6'd0, rn, rd};
      OP_ORR: word = {OPC_ORR, rm, 6'd0, rn, rd};
      OP_LSL: word = {OPC_LSL, 5'd0, shamt, rn, rd};
      OP_ORRI: begin
        word = {OPC_ORRI, imm[11:0], rn, rd};
        err  = imm > 26'(I_IMM_MAX);
      end
      OP_CBZ: begin
        word = {OPC_CBZ, imm[18:0], rd};
        err  = (simm < CB_IMM_MIN) || (simm > CB_IMM_MAX);
      end
      OP_B: word = {OPC_B, imm};
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder_loader.sv
// Encodes symbolic LEGv8 instructions and writes them to instruction memory.
// Ports: CLK, resetl, clear, base_addr, bus (slave), err, full, word_count; checksum under LOADER_CHECKSUM_EN.
module legv8_instr_encoder_loader
  import legv8_isa_pkg::*;
#(
  parameter  int ADDR_W      = 64,
  parameter  int DEPTH_WORDS = 64,
  localparam int CW          = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_addr,
  legv8_instr_encoder_loader_if.slave bus,
  output logic              err,
  output logic              full,
  output logic [CW-1:0]     word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  ldr_state_e        state;
  logic              live;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        op_q;
  logic [4:0]        rd_q;
  logic [4:0]        rn_q;
  logic [4:0]        rm_q;
  logic [5:0]        shamt_q;
  logic [25:0]       imm_q;
  logic [31:0]       pk_word;
  logic              pk_err;
  logic [CW-1:0]     cnt_nxt;

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cnt_nxt       = word_count + 1'b1;

  legv8_instr_pack u_pack (
    .op    (op_q),
    .rd    (rd_q),
    .rn    (rn_q),
    .rm    (rm_q),
    .shamt (shamt_q),
    .imm   (imm_q),
    .word  (pk_word),
    .err   (pk_err)
  );

  // live marks the first edge after reset release, when the
  // pointer is loaded from base_addr and in_ready comes up.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state      <= S_IDLE;
      live       <= 1'b0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err        <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      shamt_q    <= '0;
      imm_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      err <= 1'b0;
      if (!live || clear) begin
        live       <= 1'b1;
        state      <= S_IDLE;
        in_ready_q <= 1'b1;
        wr_en_q    <= 1'b0;
        addr_q     <= base_addr;
        full       <= 1'b0;
        word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
              op_q       <= bus.op;
              rd_q       <= bus.rd;
              rn_q       <= bus.rn;
              rm_q       <= bus.rm;
              shamt_q    <= bus.shamt;
              imm_q      <= bus.imm;
              in_ready_q <= 1'b0;
              state      <= S_ENC;
            end
          end
          S_ENC: begin
            if (pk_err) begin
              err        <= 1'b1;
              in_ready_q <= !full;
              state      <= S_IDLE;
            end else begin
              wr_en_q <= 1'b1;
              wdata_q <= pk_word;
              state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (bus.mem_ack) begin
              wr_en_q    <= 1'b0;
              addr_q     <= addr_q + ADDR_W'(4);
              word_count <= cnt_nxt;
              full       <= cnt_nxt == CW'(DEPTH_WORDS);
              in_ready_q <= cnt_nxt != CW'(DEPTH_WORDS);
`ifdef LOADER_CHECKSUM_EN
              checksum   <= checksum ^ wdata_q;
`endif
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder_loader.sv
// Scoreboard bench for legv8_instr_encoder_loader (DEPTH_WORDS=2).
// Expected writes are queued on issue and popped when memory acks.
module tb_legv8_instr_encoder_loader;
  import legv8_isa_pkg::*;

  localparam int AW = 64;
  localparam int DW = 2;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          resetl = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] base_addr;
  logic          err;
  logic          full;
  logic [CW-1:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  legv8_instr_encoder_loader_if #(.ADDR_W(AW)) bus_if ();

  always #5 clk = ~clk;

  legv8_instr_encoder_loader #(
    .ADDR_W      (AW),
    .DEPTH_WORDS (DW)
  ) dut (
    .CLK        (clk),
    .resetl     (resetl),
    .clear      (clear),
    .base_addr  (base_addr),
    .bus        (bus_if),
    .err        (err),
    .full       (full),
    .word_count (word_count)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ptr;
  logic [31:0] cs_model;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetl && !clear && bus_if.mem_wr_en && bus_if.mem_ack) begin
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", bus_if.mem_addr, e.addr);
        chk("wr_data", 64'(bus_if.mem_wdata), 64'(e.data));
        cs_model = cs_model ^ e.data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm,
                      input logic [5:0] sh, input logic [25:0] imm);
    int n;
    n = 0;
    bus_if.op       = op;
    bus_if.rd       = rd;
    bus_if.rn       = rn;
    bus_if.rm       = rm;
    bus_if.shamt    = sh;
    bus_if.imm      = imm;
    bus_if.in_valid = 1'b1;
    while (!bus_if.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("accept_timeout", 64'(bus_if.in_ready), 64'd1);
    step();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm,
                       input logic [5:0] sh, input logic [25:0] imm,
                       input logic [31:0] exp);
    sb.push_back(exp_t'{addr: ptr, data: exp});
    ptr = ptr + 64'd4;
    send(op, rd, rn, rm, sh, imm);
    chk("enc_no_wr", 64'(bus_if.mem_wr_en), 64'd0);
    step();
    chk("wr_lat2", 64'(bus_if.mem_wr_en), 64'd1);
    step();
  endtask

  task automatic bad(input logic [3:0] op, input logic [25:0] imm);
    int errs;
    int wrs;
    errs = 0;
    wrs  = 0;
    send(op, 5'd1, 5'd2, 5'd3, 6'd0, imm);
    for (int i = 0; i < 4; i++) begin
      if (err) errs++;
      if (bus_if.mem_wr_en) wrs++;
      step();
    end
    chk("err_pulse", 64'(errs), 64'd1);
    chk("err_no_wr", 64'(wrs), 64'd0);
    chk("err_wc", 64'(word_count), 64'd0);
  endtask

  task automatic do_clear(input logic [63:0] b);
    base_addr = b;
    clear     = 1'b1;
    step();
    clear     = 1'b0;
    cs_model  = '0;
    ptr       = b;
    chk("clr_full", 64'(full), 64'd0);
    chk("clr_addr", bus_if.mem_addr, b);
    chk("clr_wc", 64'(word_count), 64'd0);
    chk("clr_rdy", 64'(bus_if.in_ready), 64'd1);
  endtask

  task automatic chk_cs();
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(cs_model));
`endif
  endtask

  initial begin
    base_addr       = 64'h1000;
    bus_if.in_valid = 1'b0;
    bus_if.op       = '0;
    bus_if.rd       = '0;
    bus_if.rn       = '0;
    bus_if.rm       = '0;
    bus_if.shamt    = '0;
    bus_if.imm      = '0;
    bus_if.mem_ack  = 1'b0;
    cs_model        = '0;
    ptr             = 64'h1000;

    repeat (2) step();
    chk("rst_rdy", 64'(bus_if.in_ready), 64'd0);
    chk("rst_wr", 64'(bus_if.mem_wr_en), 64'd0);
    chk("rst_addr", bus_if.mem_addr, 64'd0);
    chk("rst_wdata", 64'(bus_if.mem_wdata), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    resetl = 1'b1;
    step();
    chk("rel_rdy", 64'(bus_if.in_ready), 64'd1);
    chk("rel_addr", bus_if.mem_addr, 64'h1000);

    bus_if.mem_ack = 1'b1;
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 32'h8B020023);
    chk("add_wc", 64'(word_count), 64'd1);
    chk("add_next", bus_if.mem_addr, 64'h1004);
    chk("add_full", 64'(full), 64'd0);
    issue(OP_LDUR, 5'd2, 5'd10, 5'd0, 6'd0, 26'd8, 32'hF8408142);
    chk("full_wc", 64'(word_count), 64'd2);
    chk("full_set", 64'(full), 64'd1);
    chk("full_rdy", 64'(bus_if.in_ready), 64'd0);
    chk_cs();

    bus_if.op       = OP_B;
    bus_if.imm      = 26'd7;
    bus_if.in_valid = 1'b1;
    repeat (5) step();
    bus_if.in_valid = 1'b0;
    chk("full_ign_wc", 64'(word_count), 64'd2);
    chk("full_ign_rdy", 64'(bus_if.in_ready), 64'd0);
    chk("full_ign_addr", bus_if.mem_addr, 64'h1008);

    do_clear(64'h2000);
    issue(OP_LSL, 5'd4, 5'd4, 5'd0, 6'd3, 26'd0, 32'hD3600C84);
    issue(OP_CBZ, 5'd5, 5'd0, 5'd0, 6'd0, 26'h3FFFFFE, 32'hB4FFFFC5);
    chk_cs();

    do_clear(64'h3000);
    issue(OP_B, 5'd0, 5'd0, 5'd0, 6'd0, 26'd3, 32'h14000003);
    issue(OP_ORRI, 5'd1, 5'd0, 5'd0, 6'd0, 26'hFFF, 32'hB23FFC01);
    chk_cs();

    do_clear(64'h4000);
    bad(OP_ORRI, 26'd4096);
    bad(OP_LDUR, 26'd256);
    bad(4'd12, 26'd0);
    bad(OP_CBZ, 26'h0040000);
    bad(OP_STUR, 26'h3FFFEFF);
    issue(OP_LDUR, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFF00, 32'hF8500000);
    issue(OP_STUR, 5'd0, 5'd0, 5'd0, 6'd0, 26'd255, 32'hF80FF000);

    do_clear(64'h5000);
    bus_if.mem_ack = 1'b0;
    sb.push_back(exp_t'{addr: 64'h5000, data: 32'h8B020023});
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_wr", 64'(bus_if.mem_wr_en), 64'd1);
      chk("stall_addr", bus_if.mem_addr, 64'h5000);
      chk("stall_data", 64'(bus_if.mem_wdata), 64'h8B020023);
      chk("stall_rdy", 64'(bus_if.in_ready), 64'd0);
      step();
    end
    bus_if.mem_ack = 1'b1;
    step();
    chk("stall_wc", 64'(word_count), 64'd1);
    chk("stall_next", bus_if.mem_addr, 64'h5004);
    chk("stall_drop", 64'(bus_if.mem_wr_en), 64'd0);

    bus_if.mem_ack = 1'b0;
    send(OP_B, 5'd0, 5'd0, 5'd0, 6'd0, 26'd9);
    step();
    chk("abort_pre_wr", 64'(bus_if.mem_wr_en), 64'd1);
    base_addr      = 64'h6000;
    clear          = 1'b1;
    bus_if.mem_ack = 1'b1;
    step();
    clear          = 1'b0;
    cs_model       = '0;
    chk("abort_wr", 64'(bus_if.mem_wr_en), 64'd0);
    chk("abort_wc", 64'(word_count), 64'd0);
    chk("abort_addr", bus_if.mem_addr, 64'h6000);
    chk_cs();

    bus_if.mem_ack = 1'b0;
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    step();
    chk("rstw_pre_wr", 64'(bus_if.mem_wr_en), 64'd1);
    #1 resetl = 1'b0;
    #1;
    chk("rstw_wr", 64'(bus_if.mem_wr_en), 64'd0);
    chk("rstw_rdy", 64'(bus_if.in_ready), 64'd0);
    chk("rstw_addr", bus_if.mem_addr, 64'd0);
    step();
    resetl = 1'b1;
    step();
    chk("rstw_rel_rdy", 64'(bus_if.in_ready), 64'd1);
    chk("rstw_rel_addr", bus_if.mem_addr, 64'h6000);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
